// File: rtl/bht_update_queue_pkg.sv
// ============================================================================
// Module : bht_update_queue_pkg
// Brief  : Branch-resolution, BHT-update and queue-entry types shared by the
//          BHT update queue and its FIFO.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package bht_update_queue_pkg;

   localparam int unsigned VLEN = 64;

   typedef enum logic [2:0] {
      NoCF   = 3'd0,
      Branch = 3'd1,
      Jump   = 3'd2,
      JumpR  = 3'd3,
      Return = 3'd4
   } cf_t;

   typedef struct packed {
      logic            valid;
      logic [VLEN-1:0] pc;
      logic            is_mispredict;
      logic            is_taken;
      cf_t             cf_type;
   } bp_resolve_t;

   typedef struct packed {
      logic            valid;
      logic [VLEN-1:0] pc;
      logic            taken;
   } bht_update_t;

   typedef struct packed {
      logic [VLEN-1:0] pc;
      logic            taken;
      logic            mispredict;
   } bht_upd_entry_t;

endpackage

`default_nettype wire

// File: rtl/bht_upd_fifo.sv
// ============================================================================
// Module : bht_upd_fifo
// Brief  : In-order DEPTH-entry FIFO of BHT update entries with synchronous
//          reset, flush, and full/empty/count status.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bht_upd_fifo
   import bht_update_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  bht_upd_entry_t           data_i,
   input  logic                     pop_i,
   output bht_upd_entry_t           data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] C_FULL = (PTR_W+1)'(DEPTH);

   logic [PTR_W-1:0] r_rptr;
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W:0]   r_count;
   bht_upd_entry_t   r_mem [DEPTH];

   logic w_push;
   logic w_pop;

   assign full_o  = (r_count == C_FULL);
   assign empty_o = (r_count == '0);
   assign count_o = r_count;
   assign data_o  = r_mem[r_rptr];

   // A push into a full FIFO is only legal when the head leaves in the same cycle.
   assign w_pop  = pop_i && !empty_o;
   assign w_push = push_i && (!full_o || w_pop);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rptr  <= '0;
         r_wptr  <= '0;
         r_count <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_mem[i] <= '0;
         end
      end else if (flush_i) begin
         r_rptr  <= '0;
         r_wptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= data_i;
            r_wptr        <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/bht_update_queue.sv
// ============================================================================
// Module : bht_update_queue
// Brief  : Filters resolved conditional branches into an in-order FIFO and
//          issues one BHT update per cycle. Optional statistics counters are
//          built when BHT_UPD_STATS_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bht_update_queue
   import bht_update_queue_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned STAT_W = 32
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                flush_i,
   input  logic                debug_mode_i,
   input  bp_resolve_t         resolved_branch_i,
   input  logic                bht_ready_i,
   output bht_update_t         bht_update_o,
   output logic                full_o,
   output logic                empty_o,
   output logic [STAT_W-1:0]   stat_updates_o,
   output logic [STAT_W-1:0]   stat_mispredicts_o,
   output logic [STAT_W-1:0]   stat_drops_o
);

   logic                     w_push_req;
   logic                     w_issue;
   logic                     w_pop;
   logic                     w_drop;
   logic                     w_full;
   logic                     w_empty;
   logic [$clog2(DEPTH):0]   w_count;
   bht_upd_entry_t           w_in_entry;
   bht_upd_entry_t           w_head;

   assign w_push_req = resolved_branch_i.valid && (resolved_branch_i.cf_type == Branch)
                       && !debug_mode_i && !flush_i;
   assign w_issue    = (w_count != '0) && !debug_mode_i;
   assign w_pop      = w_issue && bht_ready_i;
   assign w_drop     = w_push_req && w_full && !w_pop;

   assign w_in_entry.pc         = resolved_branch_i.pc;
   assign w_in_entry.taken      = resolved_branch_i.is_taken;
   assign w_in_entry.mispredict = resolved_branch_i.is_mispredict;

   bht_upd_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush_i),
      .push_i  (w_push_req && !w_drop),
      .data_i  (w_in_entry),
      .pop_i   (w_pop),
      .data_o  (w_head),
      .full_o  (w_full),
      .empty_o (w_empty),
      .count_o (w_count)
   );

   assign full_o  = w_full;
   assign empty_o = w_empty;

   always_comb begin
      bht_update_o = '0;
      if (w_issue) begin
         bht_update_o.valid = 1'b1;
         bht_update_o.pc    = w_head.pc;
         bht_update_o.taken = w_head.taken;
      end
   end

`ifdef BHT_UPD_STATS_EN
   logic [STAT_W-1:0] r_stat_updates;
   logic [STAT_W-1:0] r_stat_mispredicts;
   logic [STAT_W-1:0] r_stat_drops;

   // Saturating counters; flush leaves them alone so history survives pipeline flushes.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_stat_updates     <= '0;
         r_stat_mispredicts <= '0;
         r_stat_drops       <= '0;
      end else begin
         if (w_pop && !(&r_stat_updates)) begin
            r_stat_updates <= r_stat_updates + 1'b1;
         end
         if (w_pop && w_head.mispredict && !(&r_stat_mispredicts)) begin
            r_stat_mispredicts <= r_stat_mispredicts + 1'b1;
         end
         if (w_drop && !(&r_stat_drops)) begin
            r_stat_drops <= r_stat_drops + 1'b1;
         end
      end
   end

   assign stat_updates_o     = r_stat_updates;
   assign stat_mispredicts_o = r_stat_mispredicts;
   assign stat_drops_o       = r_stat_drops;
`else
   logic w_unused_stats;
   assign w_unused_stats     = w_head.mispredict ^ w_drop;
   assign stat_updates_o     = '0;
   assign stat_mispredicts_o = '0;
   assign stat_drops_o       = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bht_update_queue.sv
// ============================================================================
// Module : tb_bht_update_queue
// Brief  : Randomized and scenario-driven bench for bht_update_queue against
//          a queue-based reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_bht_update_queue;
   import bht_update_queue_pkg::*;

   localparam int DEPTH  = 4;
   localparam int STAT_W = 32;

   typedef struct {
      logic [63:0] pc;
      logic        taken;
      logic        mis;
   } ent_t;

   logic              clk = 1'b0;
   logic              rst_i = 1'b1;
   logic              flush_i = 1'b0;
   logic              debug_mode_i = 1'b0;
   logic              bht_ready_i = 1'b0;
   bp_resolve_t       rb = '0;
   bht_update_t       upd;
   logic              full_o;
   logic              empty_o;
   logic [STAT_W-1:0] s_upd;
   logic [STAT_W-1:0] s_mis;
   logic [STAT_W-1:0] s_drop;

   int          checks   = 0;
   int          failures = 0;
   ent_t        q[$];
   logic [31:0] m_upd  = '0;
   logic [31:0] m_mis  = '0;
   logic [31:0] m_drop = '0;

   bht_update_queue #(
      .DEPTH  (DEPTH),
      .STAT_W (STAT_W)
   ) dut (
      .clk_i              (clk),
      .rst_i              (rst_i),
      .flush_i            (flush_i),
      .debug_mode_i       (debug_mode_i),
      .resolved_branch_i  (rb),
      .bht_ready_i        (bht_ready_i),
      .bht_update_o       (upd),
      .full_o             (full_o),
      .empty_o            (empty_o),
      .stat_updates_o     (s_upd),
      .stat_mispredicts_o (s_mis),
      .stat_drops_o       (s_drop)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // Drive one cycle of inputs, check outputs against the model, then advance the model.
   task automatic step(input logic r, input logic f, input logic d, input logic v,
                       input cf_t cf, input logic [63:0] pc, input logic tk,
                       input logic mp, input logic rdy);
      logic ev;
      logic pop;
      logic push_req;
      @(negedge clk);
      rst_i            = r;
      flush_i          = f;
      debug_mode_i     = d;
      rb.valid         = v;
      rb.cf_type       = cf;
      rb.pc            = pc;
      rb.is_taken      = tk;
      rb.is_mispredict = mp;
      bht_ready_i      = rdy;
      #1;
      ev = (q.size() != 0) && !d;
      check_eq("valid", 64'(upd.valid), 64'(ev));
      if (ev) begin
         check_eq("pc", upd.pc, q[0].pc);
         check_eq("taken", 64'(upd.taken), 64'(q[0].taken));
      end else if (q.size() == 0) begin
         check_eq("pc_empty", upd.pc, 64'd0);
         check_eq("taken_empty", 64'(upd.taken), 64'd0);
      end
      check_eq("full", 64'(full_o), 64'(q.size() == DEPTH));
      check_eq("empty", 64'(empty_o), 64'(q.size() == 0));
`ifdef BHT_UPD_STATS_EN
      check_eq("stat_updates", 64'(s_upd), 64'(m_upd));
      check_eq("stat_mispredicts", 64'(s_mis), 64'(m_mis));
      check_eq("stat_drops", 64'(s_drop), 64'(m_drop));
`else
      check_eq("stat_updates_off", 64'(s_upd), 64'd0);
      check_eq("stat_mispredicts_off", 64'(s_mis), 64'd0);
      check_eq("stat_drops_off", 64'(s_drop), 64'd0);
`endif
      if (r) begin
         q.delete();
         m_upd  = '0;
         m_mis  = '0;
         m_drop = '0;
      end else begin
         pop      = ev && rdy;
         push_req = v && (cf == Branch) && !d && !f;
         if (pop) begin
            m_upd = sat_inc(m_upd);
            if (q[0].mis) m_mis = sat_inc(m_mis);
         end
         if (f) begin
            q.delete();
         end else if (push_req && (q.size() == DEPTH) && !pop) begin
            m_drop = sat_inc(m_drop);
         end else begin
            if (pop) void'(q.pop_front());
            if (push_req) q.push_back('{pc, tk, mp});
         end
      end
   endtask

   task automatic idle(input logic d, input logic rdy);
      step(1'b0, 1'b0, d, 1'b0, NoCF, 64'd0, 1'b0, 1'b0, rdy);
   endtask

   task automatic br(input logic [63:0] pc, input logic tk, input logic mp, input logic rdy);
      step(1'b0, 1'b0, 1'b0, 1'b1, Branch, pc, tk, mp, rdy);
   endtask

   function automatic cf_t rand_cf();
      case ($urandom_range(0, 7))
         0:       return NoCF;
         1:       return Jump;
         2:       return JumpR;
         3:       return Return;
         default: return Branch;
      endcase
   endfunction

   initial begin
      step(1'b1, 1'b0, 1'b0, 1'b0, NoCF, 64'd0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1, Branch, 64'h1234, 1'b1, 1'b1, 1'b1);

      // single taken branch, then a JALR that must be ignored
      br(64'h8000_0040, 1'b1, 1'b0, 1'b1);
      idle(1'b0, 1'b1);
      idle(1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1, JumpR, 64'h8000_0100, 1'b1, 1'b0, 1'b1);
      idle(1'b0, 1'b1);

      // overflow with ready low, then drain
      for (int i = 0; i < 5; i++) br(64'h8000_1000 + 64'(i * 4), i[0], i[1], 1'b0);
      idle(1'b0, 1'b0);
      for (int i = 0; i < 6; i++) idle(1'b0, 1'b1);

      // full with simultaneous push and pop
      for (int i = 0; i < 4; i++) br(64'h8000_2000 + 64'(i * 4), 1'b1, 1'b1, 1'b0);
      br(64'h8000_2FF0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 6; i++) idle(1'b0, 1'b1);

      // debug holds entries, then drains
      for (int i = 0; i < 3; i++) br(64'h8000_3000 + 64'(i * 4), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b1, Branch, 64'h9000, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) idle(1'b0, 1'b1);

      // flush with simultaneous push, then reset mid-drain
      br(64'h8000_4000, 1'b1, 1'b0, 1'b0);
      br(64'h8000_4004, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b1, Branch, 64'h8000_4008, 1'b1, 1'b1, 1'b1);
      idle(1'b0, 1'b1);
      for (int i = 0; i < 3; i++) br(64'h8000_5000 + 64'(i * 4), 1'b1, 1'b1, 1'b0);
      idle(1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1, Branch, 64'h8000_6000, 1'b0, 1'b0, 1'b1);
      idle(1'b0, 1'b1);

      for (int n = 0; n < 500; n++) begin
         step(($urandom_range(0, 99) == 0),
              ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 3) != 0),
              rand_cf(),
              {$urandom, $urandom},
              1'($urandom),
              1'($urandom),
              1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
